// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/ack word-addressed memory port and the MEM/WB register.
// Optional access-timeout abort is built when MEM_STAGE_TIMEOUT_EN is defined.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic        freeze,
  output logic        err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [31:0] ADDR_FIRST = 32'd1024;
  localparam logic [31:0] ADDR_LAST  = 32'd263167;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t      state_q, state_d;
  logic        mem_op, is_read, in_range;
  logic        start, done, bad_op, timeout_hit;
  logic [15:0] word_addr;

  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  dest_q, dest_d;
  logic        err_q, err_d;

  // A write wins when both enables are set, so only a pure read returns data.
  assign mem_op   = mem_r_en | mem_w_en;
  assign is_read  = mem_r_en & ~mem_w_en;
  assign in_range = (alu_result >= ADDR_FIRST) && (alu_result <= ADDR_LAST);

  // (alu_result - 1024) >> 2: the 1024 base has no bits below bit 2, so subtract on the word index.
  assign word_addr = alu_result[17:2] - 16'd256;

  assign start  = (state_q == IDLE) && mem_op && in_range;
  assign bad_op = (state_q == IDLE) && mem_op && !in_range;
  assign done   = (state_q == ACCESS) && mem_ack;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // Abort only once the count has reached 255 with no ack in that same cycle.
  assign timeout_hit = (state_q == ACCESS) && !mem_ack && (tmo_cnt_q == 8'hFF);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (start) begin
      tmo_cnt_d = 8'd0;
    end else if ((state_q == ACCESS) && !mem_ack) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_req = 1'b0;
    freeze  = 1'b0;
    case (state_q)
      IDLE: begin
        freeze = mem_op && in_range;
      end
      ACCESS: begin
        mem_req = 1'b1;
        freeze  = !mem_ack && !timeout_hit;
      end
      default: begin
        mem_req = 1'b0;
        freeze  = 1'b0;
      end
    endcase
  end

  // Request fields are captured on entry so they stay stable for the whole access.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start) begin
      mem_we_d    = mem_w_en;
      mem_addr_d  = word_addr;
      mem_wdata_d = val_rm;
    end
  end

  // MEM/WB register: a frozen cycle inserts a bubble and keeps the data fields.
  always_comb begin
    wb_en_d      = wb_en_q;
    mem_r_en_d   = mem_r_en_q;
    alu_result_d = alu_result_q;
    mem_data_d   = mem_data_q;
    dest_d       = dest_q;
    if (freeze) begin
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
    end else begin
      wb_en_d      = wb_en_in;
      mem_r_en_d   = mem_r_en;
      alu_result_d = alu_result;
      dest_d       = dest_in;
      mem_data_d   = 32'd0;
      if (done && is_read) begin
        mem_data_d = mem_rdata;
      end else if (timeout_hit && is_read) begin
        mem_data_d = TIMEOUT_DATA;
      end
    end
  end

  assign err_d = err_q | bad_op | timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'd0;
      mem_wdata_q  <= 32'd0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      alu_result_q <= 32'd0;
      mem_data_q   <= 32'd0;
      dest_q       <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_en_q      <= wb_en_d;
      mem_r_en_q   <= mem_r_en_d;
      alu_result_q <= alu_result_d;
      mem_data_q   <= mem_data_d;
      dest_q       <= dest_d;
      err_q        <= err_d;
    end
  end

  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign wb_en_out      = wb_en_q;
  assign mem_r_en_out   = mem_r_en_q;
  assign alu_result_out = alu_result_q;
  assign mem_data_out   = mem_data_q;
  assign dest_out       = dest_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads/stores, range limits, reset abort, timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en, mem_w_en;
  logic [31:0] alu_result, val_rm;
  logic [3:0]  dest_in;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_result_out, mem_data_out;
  logic [3:0]  dest_out;
  logic        freeze, err;

  int checks   = 0;
  int failures = 0;
  int fz;
  int wb_ones;
  int n;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .val_rm(val_rm), .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .freeze(freeze), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic wb, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dst);
    wb_en_in = wb; mem_r_en = rd; mem_w_en = wr;
    alu_result = alu; val_rm = rm; dest_in = dst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #3;
    chk("rst_req", mem_req, 0);
    chk("rst_wb", wb_en_out, 0);
    chk("rst_data", mem_data_out, 0);
    chk("rst_err", err, 0);
    chk("rst_freeze", freeze, 0);
    #9 rst = 1'b1;

    // ADD pass-through
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 4'd3); #1;
    chk("add_freeze0", freeze, 0);
    @(posedge clk); #2;
    chk("add_alu", alu_result_out, 32'h55);
    chk("add_wb", wb_en_out, 1);
    chk("add_dest", dest_out, 3);
    chk("add_freeze1", freeze, 0);
    $display("txn ADD alu_out=%h", alu_result_out);

    // load 0x408, ack in the fourth ACCESS cycle
    set_in(1'b1, 1'b1, 1'b0, 32'h408, 32'd0, 4'd5); #1;
    fz = int'(freeze); wb_ones = 0;
    chk("ld_req_idle", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      fz += int'(freeze); wb_ones += int'(wb_en_out);
      chk("ld_req", mem_req, 1);
      chk("ld_addr", mem_addr, 2);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    fz += int'(freeze); wb_ones += int'(wb_en_out);
    chk("ld_freeze_ack", freeze, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    set_in(1'b0, 1'b1, 1'b0, 32'h3FC, 32'd0, 4'd7); #1;
    wb_ones += int'(wb_en_out);
    chk("ld_freeze_cycles", 32'(fz), 4);
    chk("ld_data", mem_data_out, 32'hCAFE_0001);
    chk("ld_dest", dest_out, 5);
    chk("ld_rd_out", mem_r_en_out, 1);
    $display("txn LOAD 0x408 data=%h", mem_data_out);

    // out-of-range load just below the window
    chk("oor_freeze", freeze, 0);
    chk("oor_req", mem_req, 0);
    chk("oor_err_before", err, 0);
    @(posedge clk); #2;
    wb_ones += int'(wb_en_out);
    chk("ld_wb_once", 32'(wb_ones), 1);
    chk("oor_data", mem_data_out, 0);
    chk("oor_err", err, 1);
    chk("oor_req_after", mem_req, 0);
    $display("txn LOAD 0x3FC err=%0b", err);

    // store 0x400, ack in the first ACCESS cycle
    set_in(1'b0, 1'b0, 1'b1, 32'h400, 32'h1234_5678, 4'd0); #1;
    chk("st_freeze_idle", freeze, 1);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 0);
    chk("st_wdata", mem_wdata, 32'h1234_5678);
    chk("st_freeze_ack", freeze, 0);
    $display("txn STORE 0x400 wdata=%h", mem_wdata);

    // read+write together behaves as a write
    @(posedge clk); #1;
    mem_ack = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 32'h40C, 32'hA5A5_A5A5, 4'd9); #1;
    chk("st_err_sticky", err, 1);
    chk("both_freeze", freeze, 1);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222; #1;
    chk("both_we", mem_we, 1);
    chk("both_addr", mem_addr, 3);
    chk("both_wdata", mem_wdata, 32'hA5A5_A5A5);

    // highest legal address
    @(posedge clk); #1;
    mem_ack = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h403FF, 32'd0, 4'd2); #1;
    chk("both_data", mem_data_out, 0);
    chk("both_rd_out", mem_r_en_out, 1);
    chk("both_wb", wb_en_out, 1);
    chk("top_freeze", freeze, 1);
    $display("txn RW 0x40C data=%h", mem_data_out);
    @(posedge clk); #2;
    chk("top_addr", mem_addr, 16'hFFFF);
    chk("top_req", mem_req, 1);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_0F0F; #1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 32'h40400, 32'd0, 4'd1); #1;
    chk("top_data", mem_data_out, 32'h5A5A_0F0F);
    chk("past_freeze", freeze, 0);
    chk("past_req", mem_req, 0);
    $display("txn LOAD 0x403FF data=%h", mem_data_out);

    // reset in the middle of an access
    @(posedge clk); #1;
    set_in(1'b1, 1'b1, 1'b0, 32'h500, 32'd0, 4'd4); #1;
    @(posedge clk); #2;
    chk("rs_req_before", mem_req, 1);
    chk("rs_addr_before", mem_addr, 16'h40);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0); #1;
    chk("rs_req", mem_req, 0);
    chk("rs_wb", wb_en_out, 0);
    chk("rs_alu", alu_result_out, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_err", err, 0);
    chk("rs_freeze", freeze, 0);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    chk("rs_idle_req", mem_req, 0);
    set_in(1'b1, 1'b1, 1'b0, 32'h404, 32'd0, 4'd6); #1;
    chk("rs2_freeze", freeze, 1);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
    chk("rs2_addr", mem_addr, 1);
    chk("rs2_req", mem_req, 1);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0); #1;
    chk("rs2_data", mem_data_out, 32'h0BAD_F00D);
    chk("rs2_wb", wb_en_out, 1);
    chk("rs2_dest", dest_out, 6);
    $display("txn RESET+LOAD 0x404 data=%h", mem_data_out);

`ifdef MEM_STAGE_TIMEOUT_EN
    // load with ack withheld: abort after 255 ACCESS cycles
    @(posedge clk); #1;
    set_in(1'b1, 1'b1, 1'b0, 32'h408, 32'd0, 4'd8); #1;
    @(posedge clk); #2;
    n = 0;
    while (freeze && n < 400) begin
      n++;
      @(posedge clk); #2;
    end
    chk("to_cycles", 32'(n), 255);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0); #1;
    chk("to_data", mem_data_out, 32'hDEAD_BEEF);
    chk("to_err", err, 1);
    chk("to_req", mem_req, 0);
    $display("txn TIMEOUT data=%h", mem_data_out);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have clock port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have reset port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have these pipeline inputs from the EX/MEM register: wb_en_in 1, mem_r_en 1, mem_w_en 1, alu_result 32 (effective address or ALU value), val_rm 32 (store data), dest_in 4.
REQ-004 The block SHALL have these memory-port outputs: mem_req 1, mem_we 1, mem_addr 16 (word address), mem_wdata 32.
REQ-005 The block SHALL have these memory-port inputs: mem_rdata 32 and mem_ack 1; mem_ack is a one-cycle completion pulse.
REQ-006 The block SHALL have these MEM/WB register outputs: wb_en_out 1, mem_r_en_out 1, alu_result_out 32, mem_data_out 32, dest_out 4.
REQ-007 The block SHALL have freeze, output, 1 bit: stall to PC, IF/ID, ID/EX and EX/MEM registers.
REQ-008 The block SHALL have err, output, 1 bit: sticky access-error flag.

Function
REQ-009 A memory op SHALL be mem_r_en | mem_w_en; if both are set, the op is a write and mem_data_out loads 0.
REQ-010 Offset SHALL be alu_result - 32'd1024 (32-bit wrap); mem_addr = offset[17:2].
REQ-011 The access SHALL be in range iff 1024 <= alu_result <= 263167; out of range means no mem_req, freeze not asserted, read data 0, write dropped, err set to 1.
REQ-012 The FSM SHALL have states IDLE and ACCESS, with reset state IDLE.
REQ-013 IDLE SHALL go to ACCESS when an in-range memory op is present; otherwise it stays in IDLE.
REQ-014 ACCESS SHALL go to IDLE on the cycle mem_ack = 1.
REQ-015 In ACCESS, mem_req SHALL be 1, and mem_we, mem_addr and mem_wdata = val_rm SHALL be held stable until mem_ack.
REQ-016 mem_req SHALL be 0 in IDLE; mem_ack SHALL be ignored in IDLE.
REQ-017 freeze SHALL be combinational: (IDLE and in-range memory op) or (ACCESS and mem_ack = 0).
REQ-018 mem_ack in the first ACCESS cycle SHALL be legal; the minimum memory-op latency is 2 cycles.
REQ-019 When freeze = 0, the MEM/WB register SHALL load on the clock edge: wb_en_out = wb_en_in, mem_r_en_out, alu_result_out, dest_out and mem_data_out (mem_rdata for a read, else 0).
REQ-020 When freeze = 1, the MEM/WB register SHALL load a bubble: wb_en_out = 0, mem_r_en_out = 0, other fields unchanged.
REQ-021 Non-memory instructions SHALL pass through with 1-cycle latency and freeze = 0.
REQ-022 Back-to-back memory ops SHALL each re-enter ACCESS via IDLE, so each costs at least 2 cycles.

Reset
REQ-023 On rst = 0, asynchronously: state = IDLE, all MEM/WB outputs = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, err = 0, timeout counter = 0.
REQ-024 Reset asserted during ACCESS SHALL drop mem_req immediately; the pending access is abandoned and no data is written to MEM/WB.

Configuration
REQ-025 With macro MEM_STAGE_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle without mem_ack.
REQ-026 With MEM_STAGE_TIMEOUT_EN defined, when the counter reaches 255 without ack, the block SHALL abort to IDLE, force freeze = 0 that cycle, load mem_data_out = 32'hDEADBEEF for reads, and set err.
REQ-027 With MEM_STAGE_TIMEOUT_EN defined, mem_ack arriving in the same cycle the counter reaches 255 SHALL complete normally.
REQ-028 Without MEM_STAGE_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-029 The bench SHALL check: ADD, alu_result = 0x55, wb_en_in = 1, dest = 3 -> next edge alu_result_out = 0x55, wb_en_out = 1, dest_out = 3, freeze never 1.
REQ-030 The bench SHALL check: load, alu_result = 0x408, mem_ack after 3 ACCESS cycles with rdata 0xCAFE0001 -> mem_addr = 2, freeze = 1 for 4 cycles, one edge later mem_data_out = 0xCAFE0001, wb_en_out = 1 exactly once.
REQ-031 The bench SHALL check: store, alu_result = 0x400, val_rm = 0x12345678, ack in first ACCESS cycle -> mem_we = 1, mem_addr = 0, mem_wdata = 0x12345678, freeze high 1 cycle.
REQ-032 The bench SHALL check: load, alu_result = 0x3FC -> no mem_req, freeze = 0, mem_data_out = 0, err = 1 and it stays 1 until reset.
REQ-033 The bench SHALL check: rst pulsed low mid-ACCESS -> mem_req = 0 in the same cycle, outputs 0, state IDLE, and a subsequent load completes normally.
REQ-034 The bench SHALL check, with MEM_STAGE_TIMEOUT_EN: load, ack withheld -> abort after 255 ACCESS cycles, mem_data_out = 0xDEADBEEF, err = 1.
